// File: rtl/pe_array_id_cfg_ctrl.sv
// Layer tag configuration sequencer for the 6x8 PE array: latches mapping
// parameters, then streams every generated Y/X tag to the config bus.
module pe_array_id_cfg_ctrl #(
    parameter int MAX_H = 6,
    parameter int MAX_W = 8,
    parameter int XID_W = 5,
    parameter int YID_W = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [2:0]                     p_in,
    input  logic [2:0]                     q_in,
    input  logic [2:0]                     r_in,
    input  logic [2:0]                     t_in,
    input  logic [2:0]                     e_in,
    input  logic [2:0]                     t_h_in,
    input  logic [2:0]                     t_w_in,
    input  logic [2:0]                     pe_h_in,
    input  logic [3:0]                     pe_w_in,
    input  logic [1:0]                     kernel_h_in,
    input  logic                           linear_in,
    output logic [2:0]                     p,
    output logic [2:0]                     q,
    output logic [2:0]                     r,
    output logic [2:0]                     t,
    output logic [2:0]                     e,
    output logic [2:0]                     t_h,
    output logic [2:0]                     t_w,
    output logic [2:0]                     pe_h,
    output logic [3:0]                     pe_w,
    output logic [1:0]                     kernel_h,
    output logic                           linear,
    input  logic [MAX_H*MAX_W*XID_W-1:0]   filter_xid_flat,
    input  logic [MAX_H*MAX_W*XID_W-1:0]   ifmap_xid_flat,
    input  logic [MAX_H*MAX_W*XID_W-1:0]   ipsum_xid_flat,
    input  logic [MAX_H*MAX_W*XID_W-1:0]   opsum_xid_flat,
    input  logic [MAX_H*YID_W-1:0]         filter_yid_flat,
    input  logic [MAX_H*YID_W-1:0]         ifmap_yid_flat,
    input  logic [MAX_H*YID_W-1:0]         ipsum_yid_flat,
    input  logic [MAX_H*YID_W-1:0]         opsum_yid_flat,
    output logic                           cfg_valid,
    input  logic                           cfg_ready,
    output logic [1:0]                     cfg_type,
    output logic                           cfg_is_x,
    output logic [5:0]                     cfg_addr,
    output logic [XID_W-1:0]               cfg_data,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);

    typedef enum logic [2:0] {IDLE, SETTLE, STREAM_Y, STREAM_X, FIN} state_t;

    state_t     state_q;
    logic [2:0] row_q;
    logic [3:0] col_q;
    logic       hs;
    logic       illegal;
    logic       last_row, last_col;

    logic [MAX_H*MAX_W*XID_W-1:0] xsel, xshift;
    logic [MAX_H*YID_W-1:0]       ysel, yshift;
    logic [8:0]                   xbit, ybit;

    assign hs       = cfg_valid && cfg_ready;
    assign last_row = (row_q == pe_h - 3'd1);
    assign last_col = (col_q == pe_w - 4'd1);
    assign illegal  = (pe_h == 3'd0) || (pe_h > 3'(MAX_H)) ||
                      (pe_w == 4'd0) || (pe_w > 4'(MAX_W)) ||
                      (r == 3'd0) || (t_h == 3'd0) ||
                      (!linear && (e == 3'd0));

    // Payload is decoded live from the generator; cfg_addr doubles as the
    // entry index in both Y (row) and X (row*pe_w+col) phases.
    always_comb begin
        xsel = filter_xid_flat;
        ysel = filter_yid_flat;
        case (cfg_type)
            2'd1: begin xsel = ifmap_xid_flat; ysel = ifmap_yid_flat; end
            2'd2: begin xsel = ipsum_xid_flat; ysel = ipsum_yid_flat; end
            2'd3: begin xsel = opsum_xid_flat; ysel = opsum_yid_flat; end
            default: ;
        endcase
        xbit   = 9'(cfg_addr) * 9'(XID_W);
        ybit   = 9'(cfg_addr) * 9'(YID_W);
        xshift = xsel >> xbit;
        yshift = ysel >> ybit;
        if (!cfg_valid)
            cfg_data = '0;
        else if (cfg_is_x)
            cfg_data = xshift[XID_W-1:0];
        else
            cfg_data = XID_W'(yshift[YID_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            {p, q, r, t, e, t_h, t_w, pe_h} <= '0;
            pe_w      <= '0;
            kernel_h  <= '0;
            linear    <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            cfg_valid <= 1'b0;
            cfg_type  <= '0;
            cfg_is_x  <= 1'b0;
            cfg_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    p <= p_in; q <= q_in; r <= r_in; t <= t_in; e <= e_in;
                    t_h <= t_h_in; t_w <= t_w_in; pe_h <= pe_h_in;
                    pe_w <= pe_w_in; kernel_h <= kernel_h_in; linear <= linear_in;
                    busy    <= 1'b1;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    row_q    <= '0;
                    col_q    <= '0;
                    cfg_type <= '0;
                    cfg_addr <= '0;
                    cfg_is_x <= 1'b0;
                    if (illegal) begin
                        done    <= 1'b1;
                        cfg_err <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        cfg_valid <= 1'b1;
                        state_q   <= STREAM_Y;
                    end
                end
                STREAM_Y: if (hs) begin
                    if (last_row) begin
                        row_q    <= '0;
                        col_q    <= '0;
                        cfg_addr <= '0;
                        cfg_is_x <= 1'b1;
                        state_q  <= STREAM_X;
                    end else begin
                        row_q    <= row_q + 3'd1;
                        cfg_addr <= cfg_addr + 6'd1;
                    end
                end
                STREAM_X: if (hs) begin
                    cfg_addr <= cfg_addr + 6'd1;
                    col_q    <= last_col ? 4'd0 : col_q + 4'd1;
                    if (last_col) begin
                        row_q <= row_q + 3'd1;
                        if (last_row) begin
                            row_q    <= '0;
                            cfg_addr <= '0;
                            cfg_is_x <= 1'b0;
                            if (cfg_type != 2'd3) begin
                                cfg_type <= cfg_type + 2'd1;
                                state_q  <= STREAM_Y;
                            end else begin
                                cfg_valid <= 1'b0;
                                done      <= 1'b1;
                                state_q   <= FIN;
                            end
                        end
                    end
                end
                FIN: begin
                    busy     <= 1'b0;
                    cfg_type <= '0;
                    cfg_addr <= '0;
                    cfg_is_x <= 1'b0;
                    row_q    <= '0;
                    col_q    <= '0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
